aibcr3_dcc_dll_cal_seq: RTL and testbench

//  Power-up/recalibration sequencer for the DCC + DLL pair in the AIB clock path.
//  - Holds both blocks in reset, then releases the DCC and waits for dcc_done.
//  - Then releases the DLL and waits for lock.
//  - Bounded timeouts, retry on timeout or lock loss, sticky error after MAX_RETRY.
//  - Sits beside the DCC/DLL wrapper and drives its nrst/reinit pins.

---
 rtl/aibcr3_dcc_dll_cal_seq_if.sv | 24 ++
 rtl/aibcr3_dcc_dll_cal_seq.sv | 138 +++++++++++++
 tb/tb_aibcr3_dcc_dll_cal_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/aibcr3_dcc_dll_cal_seq_if.sv
// Control/status bundle between the DCC+DLL calibration sequencer and its environment.
// The master side drives the enables and the raw DCC/DLL status. The slave side is the sequencer.
interface aibcr3_dcc_dll_cal_seq_if;
    logic       cal_start;
    logic       dcc_byp;
    logic       dcc_done;
    logic       dll_lock;
    logic       dcc_nrst;
    logic       dll_reinit;
    logic       cal_done;
    logic       cal_err;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    modport master (
        output cal_start, dcc_byp, dcc_done, dll_lock,
        input  dcc_nrst, dll_reinit, cal_done, cal_err, state, retry_cnt
    );

    modport slave (
        input  cal_start, dcc_byp, dcc_done, dll_lock,
        output dcc_nrst, dll_reinit, cal_done, cal_err, state, retry_cnt
    );
endinterface

// File: rtl/aibcr3_dcc_dll_cal_seq.sv
// Power-up/recalibration sequencer for the DCC + DLL pair: reset hold, DCC cal, DLL lock, retries.
// Optional macro AIBCR3_DCC_DLL_LOCK_FILTER_EN: lock loss in DONE needs 4 consecutive low cycles.
module aibcr3_dcc_dll_cal_seq #(
    parameter int TMO_W     = 16,
    parameter int DCC_TMO   = 4096,
    parameter int DLL_TMO   = 8192,
    parameter int HOLD_CYC  = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                          clk_pll,
    input  logic                          nrst,
    aibcr3_dcc_dll_cal_seq_if.slave       cal
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_HOLD = 3'd1;
    localparam logic [2:0] S_DCC_WAIT = 3'd2;
    localparam logic [2:0] S_RETRY    = 3'd3;
    localparam logic [2:0] S_DLL_WAIT = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;

    localparam logic [TMO_W-1:0] HOLD_LAST = TMO_W'(HOLD_CYC - 1);
    localparam logic [TMO_W-1:0] DCC_LAST  = TMO_W'(DCC_TMO - 1);
    localparam logic [TMO_W-1:0] DLL_LAST  = TMO_W'(DLL_TMO - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    logic [2:0]       state_reg, state_next;
    logic [TMO_W-1:0] timer_reg, timer_next;
    logic [1:0]       retry_reg, retry_next;
    logic [1:0]       dcc_sync_reg, lock_sync_reg;
    logic             dcc_nrst_reg, dll_reinit_reg, cal_done_reg, cal_err_reg;
    logic             dcc_s, lock_s, lock_lost;

    assign dcc_s  = dcc_sync_reg[1];
    assign lock_s = lock_sync_reg[1];

`ifdef AIBCR3_DCC_DLL_LOCK_FILTER_EN
    logic [1:0] low_cnt_reg;

    // Fourth consecutive low sample while already three deep counts as loss.
    assign lock_lost = !lock_s && (low_cnt_reg == 2'd3);

    always_ff @(posedge clk_pll) begin
        if (!nrst || (state_reg != S_DONE) || lock_s) begin
            low_cnt_reg <= 2'd0;
        end else begin
            low_cnt_reg <= low_cnt_reg + 2'd1;
        end
    end
`else
    assign lock_lost = !lock_s;
`endif

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        case (state_reg)
            S_IDLE: begin
                retry_next = 2'd0;
                if (cal.cal_start) state_next = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                if (timer_reg == HOLD_LAST) state_next = cal.dcc_byp ? S_DLL_WAIT : S_DCC_WAIT;
            end
            S_DCC_WAIT: begin
                if (dcc_s)                      state_next = S_DLL_WAIT;
                else if (timer_reg == DCC_LAST) state_next = S_RETRY;
            end
            S_DLL_WAIT: begin
                if (lock_s) begin
                    state_next = S_DONE;
                    retry_next = 2'd0;
                end else if (timer_reg == DLL_LAST) begin
                    state_next = S_RETRY;
                end
            end
            S_DONE: begin
                if (lock_lost) state_next = S_RETRY;
            end
            S_RETRY: begin
                if (retry_reg >= RETRY_MAX) begin
                    state_next = S_ERR;
                end else begin
                    state_next = S_RST_HOLD;
                    retry_next = retry_reg + 2'd1;
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
        // Dropping the enable overrides every other event.
        if (!cal.cal_start) begin
            state_next = S_IDLE;
            retry_next = 2'd0;
        end
    end

    always_comb begin
        timer_next = '0;
        if ((state_next == state_reg) &&
            (state_reg == S_RST_HOLD || state_reg == S_DCC_WAIT || state_reg == S_DLL_WAIT)) begin
            timer_next = timer_reg + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_pll) begin
        if (!nrst) begin
            state_reg      <= S_IDLE;
            timer_reg      <= '0;
            retry_reg      <= 2'd0;
            dcc_sync_reg   <= 2'b00;
            lock_sync_reg  <= 2'b00;
            dcc_nrst_reg   <= 1'b0;
            dll_reinit_reg <= 1'b1;
            cal_done_reg   <= 1'b0;
            cal_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            retry_reg      <= retry_next;
            dcc_sync_reg   <= {dcc_sync_reg[0], cal.dcc_done};
            lock_sync_reg  <= {lock_sync_reg[0], cal.dll_lock};
            dcc_nrst_reg   <= (state_next == S_DCC_WAIT) || (state_next == S_DLL_WAIT) ||
                              (state_next == S_DONE);
            dll_reinit_reg <= !((state_next == S_DLL_WAIT) || (state_next == S_DONE));
            cal_done_reg   <= (state_next == S_DONE);
            cal_err_reg    <= (state_next == S_ERR);
        end
    end

    assign cal.state      = state_reg;
    assign cal.retry_cnt  = retry_reg;
    assign cal.dcc_nrst   = dcc_nrst_reg;
    assign cal.dll_reinit = dll_reinit_reg;
    assign cal.cal_done   = cal_done_reg;
    assign cal.cal_err    = cal_err_reg;
endmodule

// File: tb/tb_aibcr3_dcc_dll_cal_seq.sv
// Scoreboard bench for the DCC/DLL calibration sequencer: stimulus queues timed expectations,
// a negedge monitor pops and compares {state, dcc_nrst, dll_reinit, cal_done, cal_err, retry_cnt}.
module tb_aibcr3_dcc_dll_cal_seq;
    logic clk = 1'b0;
    logic nrst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    aibcr3_dcc_dll_cal_seq_if cal();

    aibcr3_dcc_dll_cal_seq #(
        .TMO_W(16), .DCC_TMO(64), .DLL_TMO(128), .HOLD_CYC(8), .MAX_RETRY(2)
    ) dut (
        .clk_pll(clk),
        .nrst(nrst),
        .cal(cal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic [8:0] exp;
        logic [8:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic [8:0] got;

    localparam logic [8:0] M_ALL   = 9'b111_11_1111;
    localparam logic [8:0] M_NOPIN = 9'b111_00_1111;

    function automatic logic [8:0] v(input logic [2:0] st, input logic n, input logic r,
                                     input logic d, input logic e, input logic [1:0] rc);
        return {st, n, r, d, e, rc};
    endfunction

    task automatic chk(input int dly, input string name, input logic [8:0] exp, input logic [8:0] mask);
        exp_t item;
        int   i;
        item.at = cyc + dly;
        item.name = name;
        item.exp = exp;
        item.mask = mask;
        i = 0;
        while (i < sb.size() && sb[i].at <= item.at) i++;
        sb.insert(i, item);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            got = {cal.state, cal.dcc_nrst, cal.dll_reinit, cal.cal_done, cal.cal_err, cal.retry_cnt};
            n_tests++;
            if (cur.at != cyc) begin
                n_fail++;
                $display("FAIL %s missed: due cyc=%0d checked cyc=%0d", cur.name, cur.at, cyc);
            end else if ((got & cur.mask) !== (cur.exp & cur.mask)) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got st/n/r/d/e/rc=%b required=%b (mask %b)",
                         cur.name, cyc, got, cur.exp, cur.mask);
            end else begin
                $display("[TB] %s cyc=%0d ok %b", cur.name, cyc, got);
            end
        end
    end

    logic [8:0] rst_v;

    initial begin
        rst_v = v(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        nrst = 1'b0;
        cal.cal_start = 1'b1;
        cal.dcc_byp = 1'b0;
        cal.dcc_done = 1'b0;
        cal.dll_lock = 1'b0;

        // 1. Reset held with cal_start asserted.
        tick(5);
        chk(0, "reset", rst_v, M_ALL);

        // 2. Normal calibration: 8-cycle hold, DCC done, DLL lock, 3-cycle sync+decision latency.
        nrst = 1'b1;
        chk(1, "hold_entry", v(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(8, "hold_last",  v(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(9, "dcc_wait",   v(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0), M_ALL);
        tick(19);
        cal.dcc_done = 1'b1;
        chk(2, "dcc_sync_lag", v(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(3, "dll_wait",     v(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), M_ALL);
        tick(40);
        cal.dll_lock = 1'b1;
        chk(2, "lock_sync_lag", v(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(3, "cal_done",      v(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0), M_ALL);
        tick(10);

        // 4. Lock glitch in DONE.
        cal.dll_lock = 1'b0;
`ifdef AIBCR3_DCC_DLL_LOCK_FILTER_EN
        chk(3, "glitch_filtered",  v(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0), M_ALL);
        chk(4, "glitch_filtered2", v(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0), M_ALL);
        tick(1);
        cal.dll_lock = 1'b1;
        tick(10);
        cal.dll_lock = 1'b0;
        chk(5, "low3_still_done", v(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0), M_ALL);
        chk(6, "low4_retry",      v(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), M_NOPIN);
        chk(7, "retry1_hold",     v(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1), M_ALL);
        chk(17, "relock_done",    v(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0), M_ALL);
        tick(4);
        cal.dll_lock = 1'b1;
        tick(20);
`else
        chk(3, "glitch_retry",  v(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), M_NOPIN);
        chk(4, "retry1_hold",   v(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1), M_ALL);
        chk(14, "relock_done",  v(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0), M_ALL);
        tick(1);
        cal.dll_lock = 1'b1;
        tick(20);
`endif

        // Abort from DONE.
        cal.cal_start = 1'b0;
        cal.dll_lock = 1'b0;
        chk(1, "abort_done", rst_v, M_ALL);
        tick(5);

        // 6. DCC bypass: RST_HOLD goes straight to DLL_WAIT.
        cal.dcc_byp = 1'b1;
        cal.dcc_done = 1'b0;
        tick(3);
        cal.cal_start = 1'b1;
        chk(8, "byp_hold_last", v(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(9, "byp_dll_wait",  v(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), M_ALL);
        tick(29);
        cal.dll_lock = 1'b1;
        chk(2, "byp_lock_lag", v(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(3, "byp_done",     v(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0), M_ALL);
        tick(10);
        cal.cal_start = 1'b0;
        cal.dll_lock = 1'b0;
        chk(1, "abort_done2", rst_v, M_ALL);
        tick(5);

        // 5. Abort while in DLL_WAIT.
        cal.cal_start = 1'b1;
        chk(9, "dll_wait_again", v(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), M_ALL);
        tick(12);
        cal.cal_start = 1'b0;
        chk(0, "pre_abort_dll_wait", v(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(1, "abort_dll_wait", rst_v, M_ALL);
        tick(5);

        // 3. DCC timeouts until retries are exhausted.
        cal.dcc_byp = 1'b0;
        tick(3);
        cal.cal_start = 1'b1;
        chk(72,  "tmo_minus1",   v(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(73,  "tmo_retry",    v(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), M_NOPIN);
        chk(74,  "retry1_entry", v(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1), M_ALL);
        chk(147, "retry2_entry", v(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2), M_ALL);
        chk(219, "last_retry",   v(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2), M_NOPIN);
        chk(220, "err",          v(3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2), M_ALL);
        chk(230, "err_sticky",   v(3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2), M_ALL);
        tick(235);
        cal.cal_start = 1'b0;
        chk(1, "err_clear", rst_v, M_ALL);
        tick(5);

        // 7. DCC done seen on the timeout cycle wins over the timeout.
        cal.cal_start = 1'b1;
        tick(70);
        cal.dcc_done = 1'b1;
        chk(2, "pri_pre",            v(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0), M_ALL);
        chk(3, "pri_done_over_tmo",  v(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), M_ALL);
        tick(10);
        cal.cal_start = 1'b0;
        chk(1, "final_abort", rst_v, M_ALL);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s never checked: due cyc=%0d now cyc=%0d", cur.name, cur.at, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
